dmem_arbiter: RTL

//  Shares the single byte-addressed data memory (sw/sb, lw/lbu) between two

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The request struct is sized by ARB_W; the top's WIDTH must match it.
package dmem_arb_pkg;

   localparam int ARB_W = 32;

   localparam logic MODE_WORD = 1'b0;
   localparam logic MODE_BYTE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

   typedef struct packed {
      logic [ARB_W-1:0] addr;
      logic [ARB_W-1:0] wdata;
      logic             we;
      logic             mode;
   } mem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select: core has fixed priority, but once it has been granted
// STARVE_MAX times in a row while the debug port waits, the debug port wins.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic c_valid,
   input  logic d_valid,
   output logic grant_c,
   output logic grant_d
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          force_d;

   assign force_d = d_valid && (starve_cnt == CW'(STARVE_MAX));
   assign grant_d = idle && d_valid && (!c_valid || force_d);
   assign grant_c = idle && c_valid && !force_d;

   // Counts only while D is actually waiting; any idle cycle without D resets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (idle) begin
         if (grant_d || !d_valid) begin
            starve_cnt <= '0;
         end else if (grant_c && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between the core (C) and a
// debug/DMA loader (D); one request every three cycles, with alignment check.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int WIDTH      = ARB_W,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_req_valid,
   output logic             c_req_ready,
   input  logic [WIDTH-1:0] c_addr,
   input  logic [WIDTH-1:0] c_wdata,
   input  logic             c_we,
   input  logic             c_mode,
   output logic             c_resp_valid,
   output logic [WIDTH-1:0] c_rdata,
   output logic             c_resp_err,
   input  logic             d_req_valid,
   output logic             d_req_ready,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   input  logic             d_we,
   input  logic             d_mode,
   output logic             d_resp_valid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_resp_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             MemWrite,
   output logic             AddrMode,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy
);

   arb_state_t       state, state_nxt;
   arb_port_t        owner;
   mem_req_t         req;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;
   logic             idle, grant_c, grant_d, err;

   assign idle = (state == IDLE);
   assign busy = !idle;

   dmem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk     (clk),
      .rst     (rst),
      .idle    (idle),
      .c_valid (c_req_valid),
      .d_valid (d_req_valid),
      .grant_c (grant_c),
      .grant_d (grant_d)
   );

   // A requester may present valid in any state; only IDLE can accept it.
   assign c_req_ready = grant_c;
   assign d_req_ready = grant_d;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_c || grant_d) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req   <= '0;
         owner <= PORT_C;
      end else if (grant_d) begin
         req   <= '{addr: d_addr, wdata: d_wdata, we: d_we, mode: d_mode};
         owner <= PORT_D;
      end else if (grant_c) begin
         req   <= '{addr: c_addr, wdata: c_wdata, we: c_we, mode: c_mode};
         owner <= PORT_C;
      end
   end

   assign err = (req.mode == MODE_WORD) && (req.addr[1:0] != 2'b00);

   // Stores and rejected accesses return zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == ACCESS) begin
         rsp_rdata <= (req.we || err) ? '0 : mem_rdata;
         rsp_err   <= err;
      end
   end

   // Memory bus follows the request registers, so it holds between accesses;
   // the write strobe is gated by state and therefore drops with async reset.
   assign mem_addr  = req.addr;
   assign mem_wdata = req.wdata;
   assign AddrMode  = req.mode;
   assign MemWrite  = (state == ACCESS) && req.we && !err;

   assign c_resp_valid = (state == RESP) && (owner == PORT_C);
   assign d_resp_valid = (state == RESP) && (owner == PORT_D);
   assign c_rdata      = c_resp_valid ? rsp_rdata : '0;
   assign d_rdata      = d_resp_valid ? rsp_rdata : '0;
   assign c_resp_err   = c_resp_valid && rsp_err;
   assign d_resp_err   = d_resp_valid && rsp_err;

endmodule
